// File: rtl/fp_norm_encoder.sv
// Sign-magnitude integer to 13-bit float (sign, 4-bit exp, 8-bit 0.frac), one normalizing shift per clock.
// Zero encodes in 1 cycle; nonzero takes 2 + (11 - leading-one position) cycles; DONE holds until out_ready.
module fp_norm_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_in,
   input  logic [11:0] mag_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign,
   output logic [3:0]  exp,
   output logic [7:0]  frac
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t      state;
   logic [11:0] mag_r;
   logic [3:0]  exp_r;
   logic        sign_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mag_r     <= '0;
         exp_r     <= '0;
         sign_r    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sign      <= 1'b0;
         exp       <= '0;
         frac      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (mag_in == 12'd0) begin
                     // Zero skips normalization; negative zero is folded to +0.
                     sign_r    <= 1'b0;
                     exp_r     <= '0;
                     mag_r     <= '0;
                     sign      <= 1'b0;
                     exp       <= '0;
                     frac      <= '0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     sign_r <= sign_in;
                     mag_r  <= mag_in;
                     exp_r  <= 4'd12;
                     state  <= NORM;
                  end
               end
            end
            NORM: begin
               if (mag_r[11]) begin
                  sign      <= sign_r;
                  exp       <= exp_r;
                  frac      <= mag_r[11:4];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  mag_r <= {mag_r[10:0], 1'b0};
                  exp_r <= exp_r - 4'd1;
               end
            end
            DONE: begin
               // Result registers are left untouched so they hold after the handshake.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fp_norm_encoder.md
# fp_norm_encoder

Sequential integer-to-floating-point encoder producing operands in the 13-bit format used by the FP comparator: sign, 4-bit exponent, 8-bit normalized fraction, value = (-1)^sign × 0.frac × 2^exp. It accepts a sign-magnitude integer over a valid/ready handshake, normalizes it with one left shift per clock, and presents the encoded result on a second valid/ready handshake. It sits upstream of the comparator as its operand source.

## Interface

- Parameters: none. Widths are fixed by the FP format.
- clk  in  1  system clock; all logic rising-edge triggered
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  encoder can accept an operand
- sign_in  in  1  operand sign
- mag_in  in  12  operand magnitude, unsigned
- out_valid  out  1  encoded result valid
- out_ready  in  1  consumer accepts result
- sign  out  1  encoded sign
- exp  out  4  encoded exponent
- frac  out  8  encoded fraction; frac[7] = 1 for every nonzero result

## Operation

- Internal state: mag_r[11:0], exp_r[3:0], sign_r, FSM {IDLE, NORM, DONE}.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture sign_in into sign_r and mag_in into mag_r; set exp_r = 12.
  - If mag_in == 0, go to DONE with sign_r = 0, exp_r = 0, mag_r = 0. Zero is encoded as all-zero; a negative zero is forced positive.
  - Otherwise go to NORM.
- NORM:
  - If mag_r[11] == 1, go to DONE.
  - Otherwise shift mag_r left by 1 (LSB filled with 0), decrement exp_r, and stay in NORM.
  - At most 11 shifts. exp_r never drops below 1 for a nonzero input.
- DONE:
  - out_valid = 1; sign = sign_r, exp = exp_r, frac = mag_r[11:4].
  - On out_ready, go to IDLE.
- Rounding: truncation only. mag_r[3:0] are discarded.
- For a nonzero input with its leading one at bit p (0..11): exp = p+1, frac = the 8 bits starting at the leading one, zero-padded on the right.
- Registered outputs are stable while out_valid=1 and out_ready=0. After the output handshake they hold their last value until the next result reaches DONE.
- in_ready and out_valid are never both 1. Exactly one operand is in flight at a time.
- in_valid during NORM or DONE is ignored (in_ready=0). mag_in and sign_in are don't-care outside the accept cycle.

## Timing

- Reset (synchronous, any state, including mid-NORM):
  - Next state IDLE; the in-flight operand is discarded.
  - in_ready=1, out_valid=0, sign=0, exp=0, frac=0, internal registers cleared.
- Accept occurs at the edge where in_valid && in_ready.
- Latency from accept edge to the first cycle with out_valid=1:
  - Nonzero: 2 + (11−p) cycles. Range is 2 (p=11) to 13 (p=0).
  - Zero: 1 cycle.
- The output handshake completes at the edge where out_valid && out_ready. in_ready returns 1 in the next cycle, so there is no same-cycle accept.
- Minimum operand spacing: latency + 1 cycles when out_ready is held high.
- Backpressure: DONE persists indefinitely while out_ready=0 with outputs constant.

## Test plan

- Reset mid-NORM:
  - Stimulus: accept mag_in=0x001, then assert reset at the 3rd NORM cycle.
  - Response: next cycle in_ready=1, out_valid=0, exp=0, frac=0. The next operand encodes correctly.
- Extremes, with out_ready=1:
  - mag_in=0xFFF, sign_in=0 → sign=0, exp=12, frac=0xFF, out_valid 2 cycles after accept.
  - mag_in=0x001 → exp=1, frac=0x80, out_valid 13 cycles after accept.
- Mid value:
  - sign_in=1, mag_in=0x0A5 → sign=1, exp=8, frac=0xA5, latency 6.
  - mag_in=0x123 → exp=9, frac=0x91, truncated with no rounding.
- Zero:
  - sign_in=1, mag_in=0x000 → sign=0, exp=0, frac=0x00, latency 1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and mag_in.
  - Response: outputs unchanged, in_ready=0 throughout. On out_ready=1, the handshake completes and in_ready=1 the following cycle.
- Random sweep:
  - Stimulus: 1000 random sign_in/mag_in operands with random in_valid/out_ready stalls.
  - Response: every result matches the reference formula above, and each output feeds the FP comparator with correct ordering against the integer compare of the inputs, with truncation ties allowed.
